// File: rtl/lsu_mem_master_pkg.sv
// Shared funct3 codes, FSM encodings and request-legality helpers for the
// load/store initiator.
package rv32i_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  // Stores have no unsigned variants, so BU/HU are illegal for them.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic legal;
    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we)
      legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
    return !legal;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = lo[0];
      F3_W:        bad = (lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake plus word-wide memory bus of the LSU; master is
// the LSU side, slave is the core/memory side.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_op;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_op, mem_wr
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_op, mem_wr
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract/extend and store lane merge
// for the read-modify-write path.
module lsu_align
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data,
  output logic [31:0] st_merged
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b = word[{addr_lo, 3'b000} +: 8];
    // Half lanes ignore addr[0]; a misaligned half falls back to its lane.
    lane_h = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    ld_data = 32'(lane_b);
      F3_BU:   ld_data = {24'b0, lane_b};
      F3_H:    ld_data = 32'(lane_h);
      F3_HU:   ld_data = {16'b0, lane_h};
      default: ld_data = word;
    endcase
  end

  always_comb begin
    st_merged = word;
    case (funct3)
      F3_B:    st_merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    st_merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: st_merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a byte-enable-less word memory; sub-word stores
// are read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W.
module lsu_mem_master
  import rv32i_lsu_pkg::*;
#(
  parameter int WORD_ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  lsu_mem_master_if.master bus
);

  logic [2:0]             state;
  logic [2:0]             funct3_q;
  logic [WORD_ADDR_W+1:0] addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            wbuf;
  logic [31:0]            resp_rdata_q;
  logic                   resp_err_q;
  logic                   req_bad;
  logic                   mem_active;
  logic                   mem_write;
  logic [31:0]            ld_data;
  logic [31:0]            st_merged;
  logic                   unused_addr_hi;

  // Upper address bits are intentionally dropped so accesses wrap.
  assign unused_addr_hi = ^bus.req_addr[31:WORD_ADDR_W+2];

  always_comb begin
    req_bad = f3_illegal(bus.req_we, bus.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    req_bad = req_bad | misaligned(bus.req_funct3, bus.req_addr[1:0]);
`endif
  end

  lsu_align u_align (
    .word      (bus.mem_rdata),
    .wdata     (wdata_q),
    .addr_lo   (addr_q[1:0]),
    .funct3    (funct3_q),
    .ld_data   (ld_data),
    .st_merged (st_merged)
  );

  // Reset gates the strobes directly so an in-flight write cannot land.
  assign mem_active = !rst && ((state == ST_LOAD) || (state == ST_RMW_RD) ||
                               (state == ST_WRITE));
  assign mem_write  = !rst && (state == ST_WRITE);

  assign bus.mem_op     = mem_active;
  assign bus.mem_wr     = mem_write;
  assign bus.mem_addr   = mem_active ?
                          {{(32-WORD_ADDR_W){1'b0}}, addr_q[WORD_ADDR_W+1:2]} : '0;
  assign bus.mem_wdata  = mem_write ? wbuf : '0;
  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            resp_rdata_q <= '0;
            resp_err_q   <= req_bad;
            if (req_bad)
              state <= ST_RESP;
            else if (!bus.req_we)
              state <= ST_LOAD;
            else if (bus.req_funct3 == F3_W)
              state <= ST_WRITE;
            else
              state <= ST_RMW_RD;
          end
        end
        ST_LOAD: begin
          resp_rdata_q <= ld_data;
          state        <= ST_RESP;
        end
        ST_RMW_RD: state <= ST_WRITE;
        ST_WRITE:  state <= ST_RESP;
        ST_RESP:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; control decides when they matter.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.req_valid) begin
      funct3_q <= bus.req_funct3;
      addr_q   <= bus.req_addr[WORD_ADDR_W+1:0];
      wdata_q  <= bus.req_wdata;
      wbuf     <= bus.req_wdata;
    end else if (state == ST_RMW_RD) begin
      wbuf <= st_merged;
    end
  end

endmodule
